regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
//  Shares the single register-file write port (active-low strobe, 5-bit dst, 32-bit data)
//  between two write-back requesters: A = ALU result, B = load/CSR result.
//  One-entry holding register per requester; oldest entry wins, ties broken round-robin.
//  Writes to x0 are dropped. Exports a pending-write bitmap for hazard stalls in the sequencer.
// PARAMETERS
//  DATA_WIDTH   32  width of write-back data
//  SELECT_SIZE  5   register select width; register count = 1<<SELECT_SIZE
// PORTS
//  clk_i        in   1            clock; all state on rising edge
//  reset_i      in   1            synchronous reset, active high
//  a_valid_i    in   1            requester A offers a write
//  a_ready_o    out  1            A may transfer this cycle
//  a_dst_i      in   SELECT_SIZE  A destination register
//  a_data_i     in   DATA_WIDTH   A write data
//  b_valid_i    in   1            requester B offers a write
//  b_ready_o    out  1            B may transfer this cycle
//  b_dst_i      in   SELECT_SIZE  B destination register
//  b_data_i     in   DATA_WIDTH   B write data
//  reg_we_no    out  1            register-file write strobe, active low, registered
//  reg_dst_o    out  SELECT_SIZE  register-file destination, registered
//  data_o       out  DATA_WIDTH   register-file write data, registered
//  pending_o    out  1<<SELECT_SIZE  bit d=1: a write to register d is held or on the port
// BEHAVIOUR
//  Reset (reset_i=1 at edge): holders empty, reg_we_no=1, reg_dst_o=0, data_o=0,
//   pending_o=0, rr pointer=A. Held entries are discarded.
//   While reset_i=1: a_ready_o=b_ready_o=0.
//  Transfer: X_valid_i & X_ready_o at an edge.
//   dst!=0: entry loaded into holder X, age stamp recorded.
//   dst==0: accepted and discarded; never held, never written.
//  X_ready_o = ~held_X | grant_X.
//   Depends only on registered state, never on X_valid_i.
//  Grant (combinational, from holders only):
//   - only one held -> that one
//   - both held -> older entry
//   - same-edge acceptance -> rr pointer; pointer toggles after each tie it breaks
//   - none held -> no grant
//  At the edge with a grant: reg_we_no<=0, reg_dst_o<=held dst, data_o<=held data,
//   granted holder empties (or reloads if its requester transfers the same edge).
//  No grant: reg_we_no<=1; reg_dst_o/data_o hold previous values.
//  Latency: transfer at edge N -> strobe low in cycle after edge N+1 at earliest ->
//   register file captures at edge N+2.
//  Throughput: one write per cycle total; uncontested requester sustains one per cycle.
//  Ordering: writes to the same dst from A and B reach the port in acceptance order.
//  pending_o: OR over
//   - held-A dst
//   - held-B dst
//   - reg_dst_o while reg_we_no=0
//   Bit 0 is always 0.
//  Never more than one strobe per cycle; reg_we_no never low during reset or the first
//   cycle after it.
// TESTING
//  1. Reset, A sends dst=5 data=0x1234_5678 once -> reg_we_no low exactly one cycle,
//     2nd cycle after transfer; dst=5, data matches; pending_o[5] high for 2 cycles.
//  2. A and B transfer same edge (dst 3, dst 4) -> A written, then B next cycle.
//     Repeat the tie -> B written first (rr toggled).
//  3. B transfers dst=7, A transfers dst=7 one cycle later, both held ->
//     port order B then A; final value is A's data.
//  4. A sends dst=0 data=0xFFFF_FFFF -> a_ready_o=1, reg_we_no stays 1, pending_o=0.
//  5. A valid every cycle for 8 writes, B idle -> 8 consecutive strobe-low cycles,
//     a_ready_o never drops.
//  6. Both holders full, reset_i pulsed 1 cycle -> reg_we_no=1, pending_o=0, no write
//     from dropped entries; ready low during reset, high the cycle after.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Two-requester write-back arbiter for a single register-file write port.
// Each requester has a one-entry holder. The oldest holder wins, and same-edge ties alternate round-robin.
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH  = 32,
  parameter int SELECT_SIZE = 5
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      a_valid_i,
  output logic                      a_ready_o,
  input  logic [SELECT_SIZE-1:0]    a_dst_i,
  input  logic [DATA_WIDTH-1:0]     a_data_i,
  input  logic                      b_valid_i,
  output logic                      b_ready_o,
  input  logic [SELECT_SIZE-1:0]    b_dst_i,
  input  logic [DATA_WIDTH-1:0]     b_data_i,
  output logic                      reg_we_no,
  output logic [SELECT_SIZE-1:0]    reg_dst_o,
  output logic [DATA_WIDTH-1:0]     data_o,
  output logic [(1<<SELECT_SIZE)-1:0] pending_o
);
  // Handshake: a requester transfers on any edge where valid and ready are both high.
  // Ready is derived only from holder state and reset, never from valid.

  logic                   a_held_q, a_held_d, b_held_q, b_held_d;
  logic [SELECT_SIZE-1:0] a_dst_q, b_dst_q, reg_dst_q;
  logic [DATA_WIDTH-1:0]  a_data_q, b_data_q, data_q;
  logic                   reg_we_nq;
  logic                   rr_q, rr_d;
  logic                   tie_q, tie_d;
  logic                   a_older_q, a_older_d;
  logic                   grant_a, grant_b;
  logic                   a_load, b_load;

  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_held_q && b_held_q) begin
      if (tie_q) begin
        grant_a = ~rr_q;
        grant_b = rr_q;
      end else begin
        grant_a = a_older_q;
        grant_b = ~a_older_q;
      end
    end else begin
      grant_a = a_held_q;
      grant_b = b_held_q;
    end
  end

  assign a_ready_o = ~reset_i & (~a_held_q | grant_a);
  assign b_ready_o = ~reset_i & (~b_held_q | grant_b);

  // A write to x0 completes the handshake but is never stored in a holder.
  assign a_load = a_valid_i & a_ready_o & (a_dst_i != '0);
  assign b_load = b_valid_i & b_ready_o & (b_dst_i != '0);

  always_comb begin
    a_held_d  = a_load | (a_held_q & ~grant_a);
    b_held_d  = b_load | (b_held_q & ~grant_b);
    tie_d     = tie_q;
    a_older_d = a_older_q;
    if (a_load && b_load) begin
      tie_d = 1'b1;
    end else if (a_load && b_held_d) begin
      tie_d     = 1'b0;
      a_older_d = 1'b0;
    end else if (b_load && a_held_d) begin
      tie_d     = 1'b0;
      a_older_d = 1'b1;
    end
    rr_d = rr_q ^ (a_held_q & b_held_q & tie_q);
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      a_held_q  <= 1'b0;
      b_held_q  <= 1'b0;
      a_dst_q   <= '0;
      b_dst_q   <= '0;
      a_data_q  <= '0;
      b_data_q  <= '0;
      rr_q      <= 1'b0;
      tie_q     <= 1'b0;
      a_older_q <= 1'b0;
      reg_we_nq <= 1'b1;
      reg_dst_q <= '0;
      data_q    <= '0;
    end else begin
      a_held_q  <= a_held_d;
      b_held_q  <= b_held_d;
      rr_q      <= rr_d;
      tie_q     <= tie_d;
      a_older_q <= a_older_d;
      if (a_load) begin
        a_dst_q  <= a_dst_i;
        a_data_q <= a_data_i;
      end
      if (b_load) begin
        b_dst_q  <= b_dst_i;
        b_data_q <= b_data_i;
      end
      if (grant_a) begin
        reg_we_nq <= 1'b0;
        reg_dst_q <= a_dst_q;
        data_q    <= a_data_q;
      end else if (grant_b) begin
        reg_we_nq <= 1'b0;
        reg_dst_q <= b_dst_q;
        data_q    <= b_data_q;
      end else begin
        reg_we_nq <= 1'b1;
      end
    end
  end

  always_comb begin
    pending_o = '0;
    if (a_held_q)   pending_o[a_dst_q]   = 1'b1;
    if (b_held_q)   pending_o[b_dst_q]   = 1'b1;
    if (!reg_we_nq) pending_o[reg_dst_q] = 1'b1;
    pending_o[0] = 1'b0;
  end

  assign reg_we_no = reg_we_nq;
  assign reg_dst_o = reg_dst_q;
  assign data_o    = data_q;
endmodule
